stg_frame_compositor: RTL and testbench

- Consumer end of the sprite pixel-query interface. It generates the VGA scan and drives play-field coordinates x/y to every sprite layer (player, moon, bullets, background).
- It gathers each layer's on/rgb reply, priority-muxes them into one registered 12-bit pixel, and emits hsync/vsync.
- It also performs per-frame player collision judgement with a lives/invulnerability FSM. Sits between the sprite blocks and the VGA pins.

---
 rtl/stg_video_pkg.sv | 42 ++++
 rtl/stg_vga_timing.sv | 67 ++++++
 rtl/stg_frame_compositor.sv | 174 +++++++++++++++++
 tb/tb_stg_frame_compositor.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stg_video_pkg.sv
// Shared video timing, play-field constants and layer types for the STG frame compositor.
package stg_video_pkg;

  localparam int unsigned CLK_DIV       = 4;
  localparam int unsigned H_ACTIVE      = 640;
  localparam int unsigned H_FP          = 16;
  localparam int unsigned H_SYNC        = 96;
  localparam int unsigned H_BP          = 48;
  localparam int unsigned V_ACTIVE      = 480;
  localparam int unsigned V_FP          = 10;
  localparam int unsigned V_SYNC        = 2;
  localparam int unsigned V_BP          = 33;
  localparam int unsigned FIELD_X0      = 32;
  localparam int unsigned FIELD_Y0      = 16;
  localparam int unsigned FIELD_W       = 384;
  localparam int unsigned FIELD_H       = 448;
  localparam int unsigned LIVES         = 3;
  localparam int unsigned INVULN_FRAMES = 120;

  localparam logic [11:0] BORDER_RGB = 12'h333;

  typedef enum logic [1:0] {ALIVE, INVULN, OVER} state_e;

  typedef struct packed {
    logic        on;
    logic [11:0] rgb;
  } pixel_t;

  // Fixed layer priority: player over bullets over moon over background.
  function automatic logic [11:0] layer_mux(input pixel_t      player,
                                            input pixel_t      bullet,
                                            input pixel_t      moon,
                                            input logic [11:0] bg);
    logic [11:0] c;
    if (player.on)      c = player.rgb;
    else if (bullet.on) c = bullet.rgb;
    else if (moon.on)   c = moon.rgb;
    else                c = bg;
    return c;
  endfunction

endpackage

// File: rtl/stg_vga_timing.sv
// VGA scan generator: pixel-enable divider, h/v counters, active window, raw syncs, frame tick.
module stg_vga_timing
  import stg_video_pkg::*;
#(
  parameter int unsigned ClkDiv  = CLK_DIV,
  parameter int unsigned HActive = H_ACTIVE,
  parameter int unsigned HFp     = H_FP,
  parameter int unsigned HSync   = H_SYNC,
  parameter int unsigned HBp     = H_BP,
  parameter int unsigned VActive = V_ACTIVE,
  parameter int unsigned VFp     = V_FP,
  parameter int unsigned VSync   = V_SYNC,
  parameter int unsigned VBp     = V_BP
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pe,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       active,
  output logic       frame_tick,
  output logic       hsync_raw,
  output logic       vsync_raw
);

  localparam int unsigned DivW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(ClkDiv - 1);
  localparam logic [9:0] HLast      = 10'(HActive + HFp + HSync + HBp - 1);
  localparam logic [9:0] VLast      = 10'(VActive + VFp + VSync + VBp - 1);
  localparam logic [9:0] HActEnd    = 10'(HActive);
  localparam logic [9:0] VActEnd    = 10'(VActive);
  localparam logic [9:0] HSyncStart = 10'(HActive + HFp);
  localparam logic [9:0] HSyncEnd   = 10'(HActive + HFp + HSync);
  localparam logic [9:0] VSyncStart = 10'(VActive + VFp);
  localparam logic [9:0] VSyncEnd   = 10'(VActive + VFp + VSync);

  logic [DivW-1:0] div_q;
  logic [9:0]      hcount_q, vcount_q;
  logic            h_last, v_last;

  // pe marks the last clk of each pixel period, so counters move at the pixel boundary.
  assign pe     = (div_q == DivLast);
  assign h_last = (hcount_q == HLast);
  assign v_last = (vcount_q == VLast);

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_q    <= '0;
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      div_q <= pe ? '0 : div_q + DivW'(1);
      if (pe) begin
        hcount_q <= h_last ? '0 : hcount_q + 10'd1;
        if (h_last) vcount_q <= v_last ? '0 : vcount_q + 10'd1;
      end
    end
  end

  assign hcount     = hcount_q;
  assign vcount     = vcount_q;
  assign active     = (hcount_q < HActEnd) && (vcount_q < VActEnd);
  assign frame_tick = pe && h_last && v_last;
  assign hsync_raw  = !((hcount_q >= HSyncStart) && (hcount_q < HSyncEnd));
  assign vsync_raw  = !((vcount_q >= VSyncStart) && (vcount_q < VSyncEnd));

endmodule

// File: rtl/stg_frame_compositor.sv
// Sprite layer compositor, VGA output register and player lives FSM.
// Optional HIT_FLASH_EN: blink the player (render and collision) while invulnerable.
module stg_frame_compositor
  import stg_video_pkg::*;
#(
  parameter int unsigned ClkDiv       = CLK_DIV,
  parameter int unsigned HActive      = H_ACTIVE,
  parameter int unsigned HFp          = H_FP,
  parameter int unsigned HSync        = H_SYNC,
  parameter int unsigned HBp          = H_BP,
  parameter int unsigned VActive      = V_ACTIVE,
  parameter int unsigned VFp          = V_FP,
  parameter int unsigned VSync        = V_SYNC,
  parameter int unsigned VBp          = V_BP,
  parameter int unsigned FieldX0      = FIELD_X0,
  parameter int unsigned FieldY0      = FIELD_Y0,
  parameter int unsigned FieldW       = FIELD_W,
  parameter int unsigned FieldH       = FIELD_H,
  parameter int unsigned Lives        = LIVES,
  parameter int unsigned InvulnFrames = INVULN_FRAMES
) (
  input  logic        clk,
  input  logic        reset,
  output logic [9:0]  x,
  output logic [9:0]  y,
  input  logic        player_on,
  input  logic [11:0] player_rgb,
  input  logic        bullet_on,
  input  logic [11:0] bullet_rgb,
  input  logic        moon_on,
  input  logic [11:0] moon_rgb,
  input  logic [11:0] bg_rgb,
  output logic [11:0] rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_tick,
  output logic        hit,
  output logic [2:0]  lives,
  output logic        game_over
);

  localparam int unsigned InvW = ($clog2(InvulnFrames + 1) > 4) ? $clog2(InvulnFrames + 1) : 4;
  localparam logic [9:0] FieldXLo = 10'(FieldX0);
  localparam logic [9:0] FieldXHi = 10'(FieldX0 + FieldW - 1);
  localparam logic [9:0] FieldYLo = 10'(FieldY0);
  localparam logic [9:0] FieldYHi = 10'(FieldY0 + FieldH - 1);

  logic       pe, active, hsync_raw, vsync_raw, in_field;
  logic [9:0] hcount, vcount;

  stg_vga_timing #(
    .ClkDiv  (ClkDiv),
    .HActive (HActive),
    .HFp     (HFp),
    .HSync   (HSync),
    .HBp     (HBp),
    .VActive (VActive),
    .VFp     (VFp),
    .VSync   (VSync),
    .VBp     (VBp)
  ) u_timing (
    .clk        (clk),
    .reset      (reset),
    .pe         (pe),
    .hcount     (hcount),
    .vcount     (vcount),
    .active     (active),
    .frame_tick (frame_tick),
    .hsync_raw  (hsync_raw),
    .vsync_raw  (vsync_raw)
  );

  assign in_field = (hcount >= FieldXLo) && (hcount <= FieldXHi) &&
                    (vcount >= FieldYLo) && (vcount <= FieldYHi);
  assign x = in_field ? hcount - FieldXLo : '0;
  assign y = in_field ? vcount - FieldYLo : '0;

  state_e            state_q, state_d;
  logic [2:0]        lives_q, lives_d;
  logic [InvW-1:0]   inv_cnt_q, inv_cnt_d;
  logic              hit_q, hit_d;
  logic              frame_hit_q, frame_hit_d;
  logic              player_vis, collide;
  pixel_t            player_px, bullet_px, moon_px;
  logic [11:0]       pix_d;

`ifdef HIT_FLASH_EN
  assign player_vis = player_on && !((state_q == INVULN) && inv_cnt_q[3]);
`else
  assign player_vis = player_on;
`endif

  assign player_px = '{on: player_vis, rgb: player_rgb};
  assign bullet_px = '{on: bullet_on, rgb: bullet_rgb};
  assign moon_px   = '{on: moon_on, rgb: moon_rgb};

  always_comb begin
    pix_d = '0;
    if (!active)       pix_d = '0;
    else if (!in_field) pix_d = BORDER_RGB;
    else               pix_d = layer_mux(player_px, bullet_px, moon_px, bg_rgb);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rgb   <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (pe) begin
      rgb   <= pix_d;
      hsync <= hsync_raw;
      vsync <= vsync_raw;
    end
  end

  // The tick pixel lies in blanking, so clearing on the tick never drops a real collision.
  assign collide     = pe && in_field && player_vis && (moon_on || bullet_on);
  assign frame_hit_d = frame_tick ? 1'b0 : (frame_hit_q || collide);

  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    inv_cnt_d = inv_cnt_q;
    hit_d     = 1'b0;
    if (frame_tick) begin
      unique case (state_q)
        ALIVE: begin
          if (frame_hit_q) begin
            hit_d = 1'b1;
            if (lives_q <= 3'd1) begin
              lives_d = '0;
              state_d = OVER;
            end else begin
              lives_d   = lives_q - 3'd1;
              inv_cnt_d = InvW'(InvulnFrames);
              state_d   = INVULN;
            end
          end
        end
        INVULN: begin
          if (inv_cnt_q <= InvW'(1)) begin
            inv_cnt_d = '0;
            state_d   = ALIVE;
          end else begin
            inv_cnt_d = inv_cnt_q - InvW'(1);
          end
        end
        OVER:    lives_d = '0;
        default: state_d = ALIVE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ALIVE;
      lives_q     <= 3'(Lives);
      inv_cnt_q   <= '0;
      hit_q       <= 1'b0;
      frame_hit_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      inv_cnt_q   <= inv_cnt_d;
      hit_q       <= hit_d;
      frame_hit_q <= frame_hit_d;
    end
  end

  assign hit       = hit_q;
  assign lives     = lives_q;
  assign game_over = (state_q == OVER);

endmodule

// File: tb/tb_stg_frame_compositor.sv
// Scoreboard bench for stg_frame_compositor on a shrunken screen so many frames fit the run.
module tb_stg_frame_compositor;
  import stg_video_pkg::*;

  // Shrunk geometry: 24x17 total, 16x12 active, field 8x6 at (4,2), 2 clk per pixel.
  localparam int CD     = 2;
  localparam int HT     = 24;
  localparam int VT     = 17;
  localparam int PIXF   = HT * VT;
  localparam int FRAMEC = PIXF * CD;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  x, y;
  logic        player_on, bullet_on, moon_on;
  logic [11:0] player_rgb, bullet_rgb, moon_rgb, bg_rgb;
  logic [11:0] rgb;
  logic        hsync, vsync, frame_tick, hit, game_over;
  logic [2:0]  lives;

  stg_frame_compositor #(
    .ClkDiv       (CD),
    .HActive      (16),
    .HFp          (2),
    .HSync        (3),
    .HBp          (3),
    .VActive      (12),
    .VFp          (1),
    .VSync        (2),
    .VBp          (2),
    .FieldX0      (4),
    .FieldY0      (2),
    .FieldW       (8),
    .FieldH       (6),
    .Lives        (3),
    .InvulnFrames (4)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .x          (x),
    .y          (y),
    .player_on  (player_on),
    .player_rgb (player_rgb),
    .bullet_on  (bullet_on),
    .bullet_rgb (bullet_rgb),
    .moon_on    (moon_on),
    .moon_rgb   (moon_rgb),
    .bg_rgb     (bg_rgb),
    .rgb        (rgb),
    .hsync      (hsync),
    .vsync      (vsync),
    .frame_tick (frame_tick),
    .hit        (hit),
    .lives      (lives),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h; int v; int f;
    logic pon; logic [11:0] prgb;
    logic bon; logic [11:0] brgb;
    logic mon; logic [11:0] mrgb;
    logic [11:0] bg;
    logic [9:0] ex; logic [9:0] ey;
    logic [11:0] ergb; logic ehs; logic evs;
  } vec_t;
  typedef struct { int p; logic [11:0] rgb; logic hs; logic vs; } exp_px_t;
  typedef struct { int tick; logic [2:0] lives; } exp_hit_t;

  vec_t     vecs[$];
  exp_px_t  px_q[$];
  exp_hit_t hit_q[$];
  exp_px_t  epx;
  exp_hit_t eh;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int ticks = 0;
  int t1c = 0, t2c = 0, hs_low = 0, vs_low = 0;
  logic run = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input int h, input int v, input int f,
                         input logic pon, input logic [11:0] prgb,
                         input logic bon, input logic [11:0] brgb,
                         input logic mon, input logic [11:0] mrgb,
                         input logic [11:0] bg, input logic [9:0] ex, input logic [9:0] ey,
                         input logic [11:0] ergb, input logic ehs, input logic evs);
    vecs.push_back('{h, v, f, pon, prgb, bon, brgb, mon, mrgb, bg, ex, ey, ergb, ehs, evs});
  endtask

  // Elapsed clocks since reset release; equals the DUT's cycle index within the scan.
  always @(posedge clk) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Stimulus: per-pixel layer drive, immediate x/y check, expected pixel queued.
  always @(negedge clk) begin
    int p, f, h, v;
    if (run && (cyc % CD == 0)) begin
      p = cyc / CD; f = p / PIXF; h = p % HT; v = (p / HT) % VT;
      if (f == 0) begin
        player_on = 0; player_rgb = 0; bullet_on = 0; bullet_rgb = 0;
        moon_on = 0; moon_rgb = 0; bg_rgb = 0;
      end else begin
        player_on = 1; player_rgb = 12'hF00; bullet_on = 0; bullet_rgb = 0;
        moon_on = 1; moon_rgb = 12'h0F0; bg_rgb = 12'h111;
      end
      foreach (vecs[i]) begin
        if (vecs[i].h == h && vecs[i].v == v && vecs[i].f == f) begin
          player_on = vecs[i].pon; player_rgb = vecs[i].prgb;
          bullet_on = vecs[i].bon; bullet_rgb = vecs[i].brgb;
          moon_on   = vecs[i].mon; moon_rgb   = vecs[i].mrgb;
          bg_rgb    = vecs[i].bg;
          chk($sformatf("x@(%0d,%0d)", h, v), 32'(x), 32'(vecs[i].ex));
          chk($sformatf("y@(%0d,%0d)", h, v), 32'(y), 32'(vecs[i].ey));
          px_q.push_back('{p, vecs[i].ergb, vecs[i].ehs, vecs[i].evs});
        end
      end
    end
  end

  // Pixel monitor: the registered output of pixel p appears during pixel p+1.
  always @(negedge clk) begin
    if (run && cyc > 0 && (cyc % CD == 0) && px_q.size() > 0 && px_q[0].p == cyc / CD - 1) begin
      epx = px_q.pop_front();
      tests++;
      if (rgb !== epx.rgb || hsync !== epx.hs || vsync !== epx.vs) begin
        fails++;
        $display("FAIL pixel p=%0d: rgb=%h hs=%b vs=%b, expected rgb=%h hs=%b vs=%b",
                 epx.p, rgb, hsync, vsync, epx.rgb, epx.hs, epx.vs);
      end
    end
  end

  // Frame/hit monitor: tick timing, sync duty over one whole frame, hit events.
  always @(negedge clk) begin
    if (run) begin
      if (frame_tick) begin
        ticks++;
        if (ticks == 1) t1c = cyc;
        if (ticks == 2) t2c = cyc;
      end
      if (ticks == 2) begin
        if (!hsync) hs_low++;
        if (!vsync) vs_low++;
      end
      if (hit) begin
        tests++;
        if (hit_q.size() == 0) begin
          fails++;
          $display("FAIL hit_event: unexpected hit at tick %0d lives=%0d, expected none",
                   ticks, lives);
        end else begin
          eh = hit_q.pop_front();
          if (ticks != eh.tick || lives !== eh.lives || game_over !== (eh.lives == 0)) begin
            fails++;
            $display("FAIL hit_event: tick=%0d lives=%0d over=%b, expected tick=%0d lives=%0d over=%b",
                     ticks, lives, game_over, eh.tick, eh.lives, eh.lives == 0);
          end
        end
      end
    end
  end

  initial begin
    int guard;
    int h, v;
    reset = 1'b0;
    player_on = 0; player_rgb = 0; bullet_on = 0; bullet_rgb = 0;
    moon_on = 0; moon_rgb = 0; bg_rgb = 0;

    //      h   v  f  pon prgb     bon brgb     mon mrgb     bg       ex ey ergb    hs vs
    add_vec(4,  2, 0, 0, 12'h000, 0, 12'h000, 0, 12'h000, 12'h00F, 0, 0, 12'h00F, 1, 1);
    add_vec(2,  2, 0, 1, 12'hF00, 0, 12'h000, 1, 12'h0F0, 12'h00F, 0, 0, 12'h333, 1, 1);
    add_vec(5,  3, 0, 0, 12'h000, 1, 12'h0A0, 1, 12'hA00, 12'h111, 1, 1, 12'h0A0, 1, 1);
    add_vec(6,  3, 0, 0, 12'h000, 0, 12'h000, 1, 12'h505, 12'h111, 2, 1, 12'h505, 1, 1);
    add_vec(7,  3, 0, 0, 12'h000, 0, 12'h000, 0, 12'h000, 12'h456, 3, 1, 12'h456, 1, 1);
    add_vec(9,  5, 0, 1, 12'h0F8, 1, 12'h0A0, 0, 12'h000, 12'h111, 5, 3, 12'h0F8, 1, 1);
    add_vec(11, 7, 0, 1, 12'hF00, 0, 12'h000, 1, 12'h0F0, 12'h111, 7, 5, 12'hF00, 1, 1);
    add_vec(12, 7, 0, 1, 12'hF00, 0, 12'h000, 0, 12'h000, 12'h777, 0, 0, 12'h333, 1, 1);
    add_vec(4,  8, 0, 0, 12'h000, 0, 12'h000, 0, 12'h000, 12'h777, 0, 0, 12'h333, 1, 1);
    add_vec(17, 3, 0, 0, 12'h000, 0, 12'h000, 0, 12'h000, 12'h777, 0, 0, 12'h000, 1, 1);
    add_vec(19, 3, 0, 0, 12'h000, 0, 12'h000, 0, 12'h000, 12'h777, 0, 0, 12'h000, 0, 1);
    add_vec(0, 13, 0, 0, 12'h000, 0, 12'h000, 0, 12'h000, 12'h777, 0, 0, 12'h000, 1, 0);
    add_vec(8,  5, 1, 1, 12'hF00, 0, 12'h000, 1, 12'h0F0, 12'h111, 4, 3, 12'hF00, 1, 1);

    // Overlap in frame 0 and every later frame: hit on tick 1; 4 invulnerable ticks
    // bring it back to ALIVE on tick 5, so the next overlapped frame is judged on tick 6.
    hit_q.push_back('{1, 3'd2});
    hit_q.push_back('{6, 3'd1});
    hit_q.push_back('{11, 3'd0});

    repeat (3) @(negedge clk);
    chk("reset_rgb", 32'(rgb), 32'h0);
    chk("reset_hsync", 32'(hsync), 32'h1);
    chk("reset_vsync", 32'(vsync), 32'h1);
    chk("reset_tick", 32'(frame_tick), 32'h0);
    chk("reset_hit", 32'(hit), 32'h0);
    chk("reset_lives", 32'(lives), 32'h3);
    chk("reset_over", 32'(game_over), 32'h0);

    reset = 1'b1;
    run   = 1'b1;

    guard = 0;
    while (ticks < 3 && guard < 4 * FRAMEC) begin @(negedge clk); guard++; end
    chk("budget_tick3", 32'(ticks >= 3), 32'h1);
    chk("state_invuln", 32'(u_dut.state_q == INVULN), 32'h1);
    chk("first_tick_cyc", 32'(t1c), 32'(FRAMEC - 1));
    chk("tick_period", 32'(t2c - t1c), 32'(FRAMEC));
    chk("hsync_low_clks", 32'(hs_low), 32'(3 * CD * VT));
    chk("vsync_low_clks", 32'(vs_low), 32'(2 * HT * CD));

    guard = 0;
    while (ticks < 13 && guard < 12 * FRAMEC) begin @(negedge clk); guard++; end
    chk("budget_tick13", 32'(ticks >= 13), 32'h1);
    chk("final_lives", 32'(lives), 32'h0);
    chk("final_over", 32'(game_over), 32'h1);
    chk("final_state", 32'(u_dut.state_q == OVER), 32'h1);
    chk("hits_pending", 32'(hit_q.size()), 32'h0);
    chk("pixels_pending", 32'(px_q.size()), 32'h0);

    // Mid-frame reset at screen pixel (10,5).
    guard = 0;
    h = 0; v = 0;
    do begin
      @(negedge clk);
      h = (cyc / CD) % HT; v = (cyc / CD / HT) % VT;
      guard++;
    end while (!(cyc % CD == 0 && h == 10 && v == 5) && guard < 2 * FRAMEC);
    chk("budget_midframe", 32'(h == 10 && v == 5), 32'h1);
    chk("pre_reset_rgb", 32'(u_dut.pix_d), 32'hF00);
    run   = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_reset_hcount", 32'(u_dut.hcount), 32'h0);
    chk("mid_reset_vcount", 32'(u_dut.vcount), 32'h0);
    chk("mid_reset_lives", 32'(lives), 32'h3);
    chk("mid_reset_rgb", 32'(rgb), 32'h0);
    chk("mid_reset_hsync", 32'(hsync), 32'h1);
    chk("mid_reset_vsync", 32'(vsync), 32'h1);
    chk("mid_reset_over", 32'(game_over), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
